// File: rtl/match_pkg.sv
// match_pkg: shared state encoding, coordinate width and default search geometry
package match_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN, S_FINISH} state_e;
  localparam int COORD_W = 16;
  localparam int X_LIMIT_DEF = 48;
  localparam int Y_LIMIT_DEF = 32;
  localparam int SAD_W_DEF = 32;
endpackage

// File: rtl/scan_counter.sv
// scan_counter: raster-order candidate coordinate counter that parks on the final candidate
module scan_counter
  import match_pkg::*;
#(
  parameter int X_LIMIT = X_LIMIT_DEF,
  parameter int Y_LIMIT = Y_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] xcur,
  output logic [COORD_W-1:0] ycur,
  output logic               last
);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(X_LIMIT - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(Y_LIMIT - 1);
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  // step through columns, wrapping into the next row; the final candidate is held so the last position stays visible
  always_comb begin
    last = (x_q == X_MAX) && (y_q == Y_MAX);
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance && !last) begin
      x_d = (x_q == X_MAX) ? '0 : x_q + COORD_W'(1);
      y_d = (x_q == X_MAX) ? y_q + COORD_W'(1) : y_q;
    end
  end
  // coordinate registers
  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
  end
  assign xcur = x_q;
  assign ycur = y_q;
endmodule

// File: rtl/best_match_writer.sv
// best_match_writer: raster-scan SAD search that streams every new best match to a register file
module best_match_writer
  import match_pkg::*;
#(
  parameter int X_LIMIT = X_LIMIT_DEF,
  parameter int Y_LIMIT = Y_LIMIT_DEF,
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               SadValid,
  input  logic [SAD_W-1:0]   SadValue,
  output logic [COORD_W-1:0] XCur,
  output logic [COORD_W-1:0] YCur,
  output logic               SetZeroes,
  output logic               RegWrite,
  output logic [COORD_W-1:0] XValue,
  output logic [COORD_W-1:0] YValue,
  output logic               Busy,
  output logic               Done
);
  state_e state_q, state_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [COORD_W-1:0] x_value_q, x_value_d, y_value_q, y_value_d;
  logic set_zeroes_q, set_zeroes_d, reg_write_q, reg_write_d, busy_q, busy_d, done_q, done_d;
  logic cnt_clear, cnt_advance, last;

  scan_counter #(.X_LIMIT(X_LIMIT), .Y_LIMIT(Y_LIMIT)) u_scan_counter (
    .clk    (Clk),
    .clear  (cnt_clear),
    .advance(cnt_advance),
    .xcur   (XCur),
    .ycur   (YCur),
    .last   (last)
  );

  // next state, best-cost tracking; status outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    best_sad_d = best_sad_q;
    x_value_d = x_value_q;
    y_value_d = y_value_q;
    reg_write_d = 1'b0;
    cnt_clear = !Reset;
    cnt_advance = 1'b0;
    case (state_q)
      S_IDLE: if (Start) begin
        state_d = S_CLEAR;
        best_sad_d = '1;
        cnt_clear = 1'b1;
      end
      S_CLEAR: state_d = S_SCAN;
      S_SCAN: if (SadValid) begin
        cnt_advance = 1'b1;
        if (SadValue < best_sad_q) begin
          best_sad_d = SadValue;
          reg_write_d = 1'b1;
          x_value_d = XCur;
          y_value_d = YCur;
        end
        if (last || SadValue == '0) state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase
    set_zeroes_d = state_d == S_CLEAR;
    busy_d = (state_d == S_CLEAR) || (state_d == S_SCAN);
    done_d = state_d == S_FINISH;
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      best_sad_q <= '1;
      x_value_q <= '0;
      y_value_q <= '0;
      set_zeroes_q <= 1'b0;
      reg_write_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      best_sad_q <= best_sad_d;
      x_value_q <= x_value_d;
      y_value_q <= y_value_d;
      set_zeroes_q <= set_zeroes_d;
      reg_write_q <= reg_write_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign SetZeroes = set_zeroes_q;
  assign RegWrite = reg_write_q;
  assign XValue = x_value_q;
  assign YValue = y_value_q;
  assign Busy = busy_q;
  assign Done = done_q;
endmodule
